// File: rtl/i2s_pkg.sv
// Shared encodings for the I2S frame sequencer: channel-select codes, FSM states, default slot width.
// Pure declarations; no timing or flow-control behaviour of its own.
package i2s_pkg;

    localparam int WIDTH_DEF = 24;

    localparam logic [1:0] CH_NONE = 2'b00;
    localparam logic [1:0] CH_C1   = 2'b01;
    localparam logic [1:0] CH_C2   = 2'b10;
    localparam logic [1:0] CH_SUM  = 2'b11;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        DRAIN = 2'd2
    } seq_state_t;

endpackage

// File: rtl/i2s_cfg_shadow.sv
// Channel-select shadow: one-deep pending register, loads on the cycle after frame_start (or next cycle when idle).
// Backpressure: cfg_ready drops while a value is pending; optional I2S_SEQ_MUTE_EN adds a frame-aligned mute.
module i2s_cfg_shadow
    import i2s_pkg::*;
(
    input  logic       sck,
    input  logic       reset_n,
    input  logic       cfg_valid,
    input  logic [1:0] cfg_sel,
`ifdef I2S_SEQ_MUTE_EN
    input  logic       mute,
`endif
    input  logic       frame_start,
    input  logic       idle,
    output logic       cfg_ready,
    output logic [1:0] channel_sel
);

    logic       pending;
    logic [1:0] pend_sel;
    logic [1:0] held_sel;
    logic       accept;
    logic       load_pt;

    assign cfg_ready = ~pending;
    assign accept    = cfg_valid && ~pending;
    // An accept landing on a load point bypasses the pending register.
    assign load_pt   = frame_start || idle;

    always_ff @(posedge sck or negedge reset_n) begin
        if (!reset_n) begin
            pending  <= 1'b0;
            pend_sel <= CH_NONE;
            held_sel <= CH_NONE;
        end else if (load_pt) begin
            if (pending) begin
                held_sel <= pend_sel;
                pending  <= 1'b0;
            end else if (accept) begin
                held_sel <= cfg_sel;
            end
        end else if (accept) begin
            pending  <= 1'b1;
            pend_sel <= cfg_sel;
        end
    end

`ifdef I2S_SEQ_MUTE_EN
    logic mute_act;

    always_ff @(posedge sck or negedge reset_n) begin
        if (!reset_n) begin
            mute_act <= 1'b0;
        end else if (load_pt) begin
            mute_act <= mute;
        end
    end

    assign channel_sel = mute_act ? CH_NONE : held_sel;
`else
    assign channel_sel = held_sel;
`endif

endmodule

// File: rtl/i2s_frame_sequencer.sv
// I2S frame sequencer: IDLE/RUN/DRAIN FSM, bit/slot/frame strobes registered, first strobes one cycle after enable.
// No backpressure on timing; config handshake via cfg_valid/cfg_ready. Optional mute port under I2S_SEQ_MUTE_EN.
module i2s_frame_sequencer
    import i2s_pkg::*;
#(
    parameter int WIDTH = WIDTH_DEF,
    parameter int DIV   = 4
) (
    input  logic       sck,
    input  logic       reset_n,
    input  logic       enable,
    input  logic       cfg_valid,
    input  logic [1:0] cfg_sel,
`ifdef I2S_SEQ_MUTE_EN
    input  logic       mute,
`endif
    output logic       cfg_ready,
    output logic       bit_strobe,
    output logic       ws_out,
    output logic       slot_start,
    output logic       frame_start,
    output logic [1:0] channel_sel,
    output logic       busy
);

    seq_state_t state;
    seq_state_t nxt_state;
    logic [3:0] div_cnt;
    logic [3:0] nxt_div;
    logic [4:0] bit_cnt;
    logic [4:0] nxt_bit;
    logic       nxt_ws;
    logic       last_div;
    logic       frame_end;
    logic       nxt_active;
    logic       nxt_bit0;

    assign last_div  = (div_cnt == 4'(DIV - 1));
    assign frame_end = ws_out && last_div && (bit_cnt == 5'(WIDTH - 1));

    always_comb begin
        nxt_state = state;
        nxt_div   = '0;
        nxt_bit   = '0;
        nxt_ws    = 1'b0;
        if (state == IDLE) begin
            if (enable) nxt_state = RUN;
        end else begin
            // Dropping enable only takes effect once the right slot has finished.
            if (!enable && frame_end) nxt_state = IDLE;
            else if (enable)          nxt_state = RUN;
            else                      nxt_state = DRAIN;

            if (nxt_state != IDLE) begin
                nxt_ws = ws_out;
                if (last_div) begin
                    if (bit_cnt == 5'(WIDTH - 1)) begin
                        nxt_ws = ~ws_out;
                    end else begin
                        nxt_bit = bit_cnt + 5'd1;
                    end
                end else begin
                    nxt_div = div_cnt + 4'd1;
                    nxt_bit = bit_cnt;
                end
            end
        end
    end

    assign nxt_active = (nxt_state != IDLE);
    assign nxt_bit0   = nxt_active && (nxt_div == 4'd0);

    always_ff @(posedge sck or negedge reset_n) begin
        if (!reset_n) begin
            state       <= IDLE;
            div_cnt     <= '0;
            bit_cnt     <= '0;
            ws_out      <= 1'b0;
            busy        <= 1'b0;
            bit_strobe  <= 1'b0;
            slot_start  <= 1'b0;
            frame_start <= 1'b0;
        end else begin
            state       <= nxt_state;
            div_cnt     <= nxt_div;
            bit_cnt     <= nxt_bit;
            ws_out      <= nxt_ws;
            busy        <= nxt_active;
            bit_strobe  <= nxt_bit0;
            slot_start  <= nxt_bit0 && (nxt_bit == 5'd0);
            frame_start <= nxt_bit0 && (nxt_bit == 5'd0) && !nxt_ws;
        end
    end

    i2s_cfg_shadow u_cfg_shadow (
        .sck         (sck),
        .reset_n     (reset_n),
        .cfg_valid   (cfg_valid),
        .cfg_sel     (cfg_sel),
`ifdef I2S_SEQ_MUTE_EN
        .mute        (mute),
`endif
        .frame_start (frame_start),
        .idle        (~busy),
        .cfg_ready   (cfg_ready),
        .channel_sel (channel_sel)
    );

endmodule

// File: tb/tb_i2s_frame_sequencer.sv
// Bench for i2s_frame_sequencer: WIDTH=24/DIV=4 main instance plus a WIDTH=2/DIV=1 corner instance.
// Mute scenario is compiled in when I2S_SEQ_MUTE_EN is defined.
module tb_i2s_frame_sequencer;
    import i2s_pkg::*;

    localparam int W  = 24;
    localparam int D  = 4;
    localparam int FR = 2 * W * D;

    logic sck = 1'b0;
    always #5 sck = ~sck;

    logic       reset_n, enable, cfg_valid;
    logic [1:0] cfg_sel;
    logic       cfg_ready, bit_strobe, ws_out, slot_start, frame_start, busy;
    logic [1:0] channel_sel;

    logic       enable2, cfg_valid2;
    logic [1:0] cfg_sel2;
    logic       cfg_ready2, bit_strobe2, ws_out2, slot_start2, frame_start2, busy2;
    logic [1:0] channel_sel2;
`ifdef I2S_SEQ_MUTE_EN
    logic       mute, mute2;
`endif

    int n_pass  = 0;
    int n_total = 0;

    logic [4:0] exp_q[$];
    typedef struct {
        logic [1:0] sel;
        int         cyc;
    } cfg_exp_t;
    cfg_exp_t cfg_q[$];

    i2s_frame_sequencer #(.WIDTH(W), .DIV(D)) dut (
        .sck(sck), .reset_n(reset_n), .enable(enable),
        .cfg_valid(cfg_valid), .cfg_sel(cfg_sel),
`ifdef I2S_SEQ_MUTE_EN
        .mute(mute),
`endif
        .cfg_ready(cfg_ready), .bit_strobe(bit_strobe), .ws_out(ws_out),
        .slot_start(slot_start), .frame_start(frame_start),
        .channel_sel(channel_sel), .busy(busy)
    );

    i2s_frame_sequencer #(.WIDTH(2), .DIV(1)) dut2 (
        .sck(sck), .reset_n(reset_n), .enable(enable2),
        .cfg_valid(cfg_valid2), .cfg_sel(cfg_sel2),
`ifdef I2S_SEQ_MUTE_EN
        .mute(mute2),
`endif
        .cfg_ready(cfg_ready2), .bit_strobe(bit_strobe2), .ws_out(ws_out2),
        .slot_start(slot_start2), .frame_start(frame_start2),
        .channel_sel(channel_sel2), .busy(busy2)
    );

    task automatic tick();
        @(posedge sck);
        #1;
    endtask

    // Expected {bit_strobe, slot_start, frame_start, ws_out, busy} at cycle k after the enable edge.
    function automatic logic [4:0] model(input int k, input int stop);
        int pos;
        if (stop >= 0 && k >= stop) return 5'b0;
        pos = k % FR;
        return {pos % D == 0, pos % (W * D) == 0, pos == 0, pos >= W * D, 1'b1};
    endfunction

    task automatic do_reset();
        reset_n   = 1'b0;
        enable    = 1'b0;
        cfg_valid = 1'b0;
        cfg_sel   = CH_NONE;
        repeat (3) tick();
        @(negedge sck);
        reset_n = 1'b1;
        tick();
    endtask

    task automatic run_frames(input string name, input int drop_at, input int resume_at, input int ncyc);
        int stop;
        logic [4:0] obs, e;
        stop = -1;
        if (drop_at >= 0) begin
            stop = (drop_at / FR + 1) * FR;
            if (resume_at >= 0 && resume_at < stop) stop = -1;
        end
        exp_q.delete();
        enable = 1'b1;
        exp_q.push_back(model(0, stop));
        tick();
        for (int c = 0; c < ncyc; c++) begin
            obs = {bit_strobe, slot_start, frame_start, ws_out, busy};
            e   = exp_q.pop_front();
            n_total++;
            if (obs !== e)
                $display("FAIL %s cycle %0d: bs/ss/fs/ws/busy=%b, expected %b", name, c, obs, e);
            else
                n_pass++;
            if (c == drop_at)   enable = 1'b0;
            if (c == resume_at) enable = 1'b1;
            if (c + 1 < ncyc) exp_q.push_back(model(c + 1, stop));
            tick();
        end
        enable = 1'b0;
    endtask

    task automatic test_reset();
        reset_n = 1'b0;
        repeat (2) tick();
        n_total++;
        if ({bit_strobe, slot_start, frame_start, ws_out, busy} !== 5'b0)
            $display("FAIL reset_strobes: got %b, expected 00000", {bit_strobe, slot_start, frame_start, ws_out, busy});
        else n_pass++;
        n_total++;
        if (cfg_ready !== 1'b1) $display("FAIL reset_cfg_ready: got %b, expected 1", cfg_ready);
        else n_pass++;
        n_total++;
        if (channel_sel !== CH_NONE) $display("FAIL reset_channel_sel: got %b, expected 00", channel_sel);
        else n_pass++;
        n_total++;
        if (busy2 !== 1'b0) $display("FAIL reset_busy2: got %b, expected 0", busy2);
        else n_pass++;
        do_reset();
    endtask

    task automatic test_frame_timing();
        do_reset();
        run_frames("frame_timing", -1, -1, 2 * FR + 10);
    endtask

    task automatic test_drain();
        do_reset();
        run_frames("drain", 50, -1, FR + 20);
    endtask

    task automatic test_drain_resume();
        do_reset();
        run_frames("drain_resume", 50, 100, 2 * FR + 10);
    endtask

    task automatic test_config();
        logic [1:0] prev;
        logic       exp_rdy;
        cfg_exp_t   ce;
        do_reset();
        cfg_q.delete();
        enable = 1'b1;
        tick();
        prev = channel_sel;
        for (int c = 0; c <= 2 * FR + 16; c++) begin
            exp_rdy = (c <= 20) || (c == FR + 1) || (c >= 2 * FR + 1);
            n_total++;
            if (cfg_ready !== exp_rdy)
                $display("FAIL cfg_ready cycle %0d: got %b, expected %b", c, cfg_ready, exp_rdy);
            else n_pass++;
            if (channel_sel !== prev) begin
                n_total++;
                if (cfg_q.size() == 0) begin
                    $display("FAIL cfg_apply: unexpected channel_sel %b at cycle %0d", channel_sel, c);
                end else begin
                    ce = cfg_q.pop_front();
                    if (channel_sel !== ce.sel || c != ce.cyc)
                        $display("FAIL cfg_apply: channel_sel=%b at cycle %0d, expected %b at cycle %0d",
                                 channel_sel, c, ce.sel, ce.cyc);
                    else n_pass++;
                end
                prev = channel_sel;
            end
            if (c == 20) begin
                cfg_valid = 1'b1;
                cfg_sel   = CH_SUM;
                cfg_q.push_back('{sel: CH_SUM, cyc: FR + 1});
            end
            if (c == 21) begin
                cfg_sel = CH_C1;
                cfg_q.push_back('{sel: CH_C1, cyc: 2 * FR + 1});
            end
            if (c == FR + 2) cfg_valid = 1'b0;
            tick();
        end
        n_total++;
        if (cfg_q.size() != 0) $display("FAIL cfg_all_applied: %0d left, expected 0", cfg_q.size());
        else n_pass++;
        n_total++;
        if (channel_sel !== CH_C1) $display("FAIL cfg_final_sel: got %b, expected 01", channel_sel);
        else n_pass++;
        enable = 1'b0;
    endtask

    task automatic test_coincident();
        logic [1:0] prev;
        cfg_exp_t   ce;
        do_reset();
        cfg_q.delete();
        enable = 1'b1;
        tick();
        prev = channel_sel;
        for (int c = 0; c <= FR + 8; c++) begin
            if (channel_sel !== prev) begin
                n_total++;
                if (cfg_q.size() == 0) begin
                    $display("FAIL coinc_apply: unexpected channel_sel %b at cycle %0d", channel_sel, c);
                end else begin
                    ce = cfg_q.pop_front();
                    if (channel_sel !== ce.sel || c != ce.cyc)
                        $display("FAIL coinc_apply: channel_sel=%b at cycle %0d, expected %b at cycle %0d",
                                 channel_sel, c, ce.sel, ce.cyc);
                    else n_pass++;
                end
                prev = channel_sel;
            end
            if (c == FR) begin
                n_total++;
                if (frame_start !== 1'b1) $display("FAIL coinc_frame_start: got %b, expected 1", frame_start);
                else n_pass++;
                cfg_valid = 1'b1;
                cfg_sel   = CH_C2;
                cfg_q.push_back('{sel: CH_C2, cyc: FR + 1});
            end
            if (c == FR + 1) begin
                cfg_valid = 1'b0;
                n_total++;
                if (cfg_ready !== 1'b1) $display("FAIL coinc_cfg_ready: got %b, expected 1", cfg_ready);
                else n_pass++;
            end
            tick();
        end
        n_total++;
        if (cfg_q.size() != 0) $display("FAIL coinc_applied: %0d left, expected 0", cfg_q.size());
        else n_pass++;
        enable = 1'b0;
    endtask

    task automatic test_idle_cfg();
        logic [1:0] vals [4];
        vals = '{CH_SUM, CH_C1, CH_C2, CH_NONE};
        do_reset();
        foreach (vals[i]) begin
            cfg_valid = 1'b1;
            cfg_sel   = vals[i];
            tick();
            cfg_valid = 1'b0;
            n_total++;
            if (channel_sel !== vals[i] || cfg_ready !== 1'b1 || busy !== 1'b0)
                $display("FAIL idle_cfg[%0d]: sel/rdy/busy=%b/%b/%b, expected %b/1/0",
                         i, channel_sel, cfg_ready, busy, vals[i]);
            else n_pass++;
            tick();
        end
    endtask

    task automatic test_reset_midframe();
        do_reset();
        cfg_valid = 1'b1;
        cfg_sel   = CH_SUM;
        tick();
        cfg_valid = 1'b0;
        enable    = 1'b1;
        tick();
        for (int c = 0; c < 70; c++) begin
            cfg_valid = (c == 30);
            cfg_sel   = CH_C1;
            tick();
        end
        cfg_valid = 1'b0;
        n_total++;
        if (channel_sel !== CH_SUM || cfg_ready !== 1'b0)
            $display("FAIL premid_state: sel/rdy=%b/%b, expected 11/0", channel_sel, cfg_ready);
        else n_pass++;
        reset_n = 1'b0;
        enable  = 1'b0;
        #2;
        n_total++;
        if ({bit_strobe, slot_start, frame_start, ws_out, busy} !== 5'b0 || channel_sel !== CH_NONE || cfg_ready !== 1'b1)
            $display("FAIL midreset_async: strobes=%b sel=%b rdy=%b, expected 00000/00/1",
                     {bit_strobe, slot_start, frame_start, ws_out, busy}, channel_sel, cfg_ready);
        else n_pass++;
        @(negedge sck);
        reset_n = 1'b1;
        for (int c = 0; c < 20; c++) begin
            tick();
            n_total++;
            if ({bit_strobe, slot_start, frame_start, ws_out, busy} !== 5'b0)
                $display("FAIL post_reset_idle cycle %0d: got %b, expected 00000", c,
                         {bit_strobe, slot_start, frame_start, ws_out, busy});
            else n_pass++;
        end
        run_frames("restart", -1, -1, FR + 10);
    endtask

    task automatic test_div1();
        logic [2:0] obs, e;
        n_total++;
        if (cfg_ready2 !== 1'b1 || channel_sel2 !== CH_NONE)
            $display("FAIL div1_idle_cfg: rdy/sel=%b/%b, expected 1/00", cfg_ready2, channel_sel2);
        else n_pass++;
        enable2 = 1'b1;
        tick();
        for (int c = 0; c < 20; c++) begin
            obs = {bit_strobe2, frame_start2, ws_out2};
            e   = {1'b1, c % 4 == 0, c % 4 >= 2};
            n_total++;
            if (obs !== e) $display("FAIL div1 cycle %0d: bs/fs/ws=%b, expected %b", c, obs, e);
            else n_pass++;
            tick();
        end
        enable2 = 1'b0;
        repeat (6) tick();
        n_total++;
        if (busy2 !== 1'b0 || bit_strobe2 !== 1'b0) $display("FAIL div1_stop: busy/bs=%b/%b, expected 0/0", busy2, bit_strobe2);
        else n_pass++;
    endtask

`ifdef I2S_SEQ_MUTE_EN
    task automatic test_mute();
        logic [1:0] e;
        cfg_valid2 = 1'b1;
        cfg_sel2   = CH_SUM;
        tick();
        cfg_valid2 = 1'b0;
        enable2    = 1'b1;
        tick();
        for (int c = 0; c < 16; c++) begin
            e = (c >= 5 && c <= 8) ? CH_NONE : CH_SUM;
            n_total++;
            if (channel_sel2 !== e) $display("FAIL mute cycle %0d: channel_sel=%b, expected %b", c, channel_sel2, e);
            else n_pass++;
            if (c == 1) mute2 = 1'b1;
            if (c == 6) mute2 = 1'b0;
            tick();
        end
        enable2 = 1'b0;
        repeat (6) tick();
    endtask
`endif

    initial begin
        reset_n    = 1'b0;
        enable     = 1'b0;
        cfg_valid  = 1'b0;
        cfg_sel    = CH_NONE;
        enable2    = 1'b0;
        cfg_valid2 = 1'b0;
        cfg_sel2   = CH_NONE;
`ifdef I2S_SEQ_MUTE_EN
        mute  = 1'b0;
        mute2 = 1'b0;
`endif
        test_reset();
        test_div1();
`ifdef I2S_SEQ_MUTE_EN
        test_mute();
`endif
        test_frame_timing();
        test_drain();
        test_drain_resume();
        test_config();
        test_coincident();
        test_idle_cfg();
        test_reset_midframe();
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

// File: doc/i2s_frame_sequencer.md
I2S_FRAME_SEQUENCER -- requirements
Module: i2s_frame_sequencer

Interface
REQ-001 The parameter list SHALL be: WIDTH, 24, bits per slot (range 2..32).
REQ-002 The parameter list SHALL include: DIV, 4, sck cycles per serial bit (range 1..16).
REQ-003 The port list SHALL start with: sck  in  1  single block clock, all logic on posedge.
REQ-004 The port list SHALL continue with: reset_n  in  1  asynchronous active-low reset.
REQ-005 The port list SHALL include: enable  in  1  run request, level-sensitive.
REQ-006 The port list SHALL include: cfg_valid  in  1  new channel-select configuration offered.
REQ-007 The port list SHALL include: cfg_sel  in  2  offered channel-select value (00 none, 01 c1, 10 c2, 11 sum).
REQ-008 The port list SHALL include: cfg_ready  out  1  configuration slot free; transfer when cfg_valid && cfg_ready.
REQ-009 The port list SHALL include: bit_strobe  out  1  one-cycle pulse per serial bit.
REQ-010 The port list SHALL include: ws_out  out  1  word select, 0 = left slot, 1 = right slot.
REQ-011 The port list SHALL include: slot_start  out  1  one-cycle pulse on the first cycle of each slot.
REQ-012 The port list SHALL include: frame_start  out  1  slot_start of a left slot.
REQ-013 The port list SHALL include: channel_sel  out  2  active selection driven to the mixer datapath.
REQ-014 The port list SHALL end with: busy  out  1  state not IDLE.

Function
REQ-015 The FSM SHALL have the states IDLE, RUN and DRAIN.
REQ-016 In IDLE with enable=1, the FSM SHALL enter RUN on the next cycle; frame_start, slot_start and bit_strobe SHALL pulse in that first RUN cycle.
REQ-017 div_cnt SHALL count 0..DIV-1 in RUN/DRAIN, and bit_strobe SHALL equal 1 when div_cnt==0 (DIV=1: every cycle).
REQ-018 bit_cnt SHALL increment when div_cnt==DIV-1 and SHALL wrap from WIDTH-1 to 0, toggling ws_out on the wrap.
REQ-019 slot_start SHALL equal 1 when bit_cnt==0 && div_cnt==0 in RUN/DRAIN; one frame SHALL be 2*WIDTH*DIV cycles.
REQ-020 On enable=0 in RUN, the FSM SHALL enter DRAIN, finish the current frame through the last right-slot cycle, then enter IDLE.
REQ-021 On enable=1 during DRAIN, the FSM SHALL return to RUN with no gap in counters or ws_out.
REQ-022 In IDLE, the counters SHALL be 0, ws_out SHALL be 0, and all strobes SHALL be 0.
REQ-023 cfg_ready SHALL be 1 when no configuration is pending; an accepted cfg_sel SHALL be held pending with cfg_ready=0.
REQ-024 A pending value SHALL load into channel_sel on the cycle after frame_start, keeping channel_sel stable for a whole frame.
REQ-025 An accept coincident with frame_start SHALL apply on the following cycle, exactly as a pending value does.
REQ-026 In IDLE, an accepted value SHALL apply on the next cycle.

Reset
REQ-027 reset_n=0 SHALL asynchronously force IDLE, clear counters and pending state, and set ws_out=0, strobes=0, busy=0, channel_sel=00 and cfg_ready=1.
REQ-028 Reset asserted mid-frame SHALL abandon the frame; after release, no strobe SHALL pulse until enable is sampled high.

Configuration
REQ-029 With I2S_SEQ_MUTE_EN defined, a mute input port (1 bit) SHALL exist; mute=1 SHALL force channel_sel=00 from the cycle after the next frame_start, and mute=0 SHALL restore the held selection at the next frame boundary.
REQ-030 Without I2S_SEQ_MUTE_EN, there SHALL be no mute port and no mute logic.

Structure
REQ-031 Package i2s_pkg SHALL hold the CH_NONE/CH_C1/CH_C2/CH_SUM encodings, the FSM state enum and the WIDTH default.
REQ-032 Sub-module i2s_cfg_shadow SHALL implement the handshake, the pending register and the frame-boundary load; the FSM and counters SHALL remain in the top.

Verification
REQ-033 Frame timing (WIDTH=24, DIV=4): enable=1 from IDLE -> frame_start every 192 cycles, slot_start every 96, ws_out toggles every 96, bit_strobe every 4.
REQ-034 DRAIN: enable=0 at cycle 50 of a frame -> strobes continue to cycle 191, then IDLE with busy=0; enable=1 again at cycle 100 -> uninterrupted frames.
REQ-035 Config: cfg_sel=11 accepted mid-frame -> cfg_ready=0 and channel_sel unchanged until the cycle after the next frame_start, then 11 with cfg_ready=1; a second offer during pending stalls.
REQ-036 Coincident accept: cfg_valid on the frame_start cycle -> channel_sel updates on the following cycle.
REQ-037 Reset: reset_n=0 at cycle 70 -> all outputs at reset values immediately; frame restarts from bit 0 after enable.
REQ-038 DIV=1, WIDTH=2 corner: bit_strobe constant 1 and frame_start every 4 cycles; with I2S_SEQ_MUTE_EN, mute=1 -> channel_sel=00 after the next frame_start.
